// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial multi-byte word adder.
// Latency: none (definitions only).
// Backpressure: not applicable.
package serial_add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/byte_add_cell.sv
// Combinational 8-bit carry-chain adder with carry-out and signed overflow.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is registered.
module byte_add_cell
    import serial_add_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] s,
    output logic              cout,
    output logic              ovf
);

    // 9-bit sum so the carry-out falls out as the top bit
    always_comb begin
        {cout, s} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
        ovf       = (a[BYTE_W-1] == b[BYTE_W-1]) & (s[BYTE_W-1] != a[BYTE_W-1]);
    end

endmodule

// File: rtl/serial_word_adder.sv
// Multi-byte adder, one LSB-first operand byte pair per beat, carry chained in a register.
// Latency: 1 cycle from accepted beat to out_valid; one beat per cycle throughput.
// Backpressure: in_ready = !out_valid | out_ready; output held stable while stalled. Macro SERIAL_ADDER_SUB_EN adds in_sub (A-B mode).
module serial_word_adder
    import serial_add_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int CNT_W  = $clog2(NBYTES) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_a,
    input  logic [BYTE_W-1:0] in_b,
    input  logic              in_first,
    input  logic              in_last,
    input  logic              in_cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic              in_sub,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_sum,
    output logic              out_last,
    output logic              out_carry,
    output logic              out_ovf,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_eff;
    logic              carry_q, carry_d;
    logic              accept, is_first, is_last, cin_eff;
    logic [BYTE_W-1:0] b_eff, s;
    logic              c8, ovf;

    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign busy     = (state_q == ST_RUN);

    // In IDLE every beat starts a word; forced-last caps the word at NBYTES
    assign is_first = in_first | (state_q == ST_IDLE);
    assign cnt_eff  = is_first ? '0 : cnt_q;
    assign is_last  = in_last | (cnt_eff == LAST_IDX);

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_q, sub_eff;

    // Subtract mode is latched from the first beat and held for the whole word
    assign sub_eff = is_first ? in_sub : sub_q;
    assign b_eff   = sub_eff ? ~in_b : in_b;
    assign cin_eff = is_first ? (sub_eff | in_cin) : carry_q;

    // Mode register for the word in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      sub_q <= 1'b0;
        else if (accept) sub_q <= sub_eff;
    end
`else
    assign b_eff   = in_b;
    assign cin_eff = is_first ? in_cin : carry_q;
`endif

    byte_add_cell u_cell (
        .a    (in_a),
        .b    (b_eff),
        .cin  (cin_eff),
        .s    (s),
        .cout (c8),
        .ovf  (ovf)
    );

    // Next state, byte index and inter-beat carry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        if (accept) begin
            if (is_last) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                carry_d = 1'b0;
            end else begin
                state_d = ST_RUN;
                cnt_d   = cnt_eff + CNT_W'(1);
                carry_d = c8;
            end
        end
    end

    // FSM, counter and carry registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    // Output stage: load on accept, otherwise drop valid once drained; data holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_carry <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sum   <= s;
            out_last  <= is_last;
            out_carry <= is_last & c8;
            out_ovf   <= is_last & ovf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/serial_word_adder.md
Name: serial_word_adder

Overview:
- Multi-byte word adder that takes one operand byte pair per beat, least-significant byte first, and carries between beats in a register.
- Sits around the team's combinational 8-bit carry-chain adder: feeds the adder its operands and carry-in, and registers its sum and carry-out.
- Lets 16/32-bit additions run on a single 8-bit adder.
- Valid/ready stream on input and output; one registered output stage.

Parameters:
- NBYTES, 4, maximum bytes per word. The beat at index NBYTES-1 is forced to be the last beat. Legal range is 1..16.
- CNT_W, $clog2(NBYTES)+1, width of the byte counter. Derived; not overridden.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- in_a  in  8  operand A byte
- in_b  in  8  operand B byte
- in_first  in  1  beat is byte 0 of a new word
- in_last  in  1  beat is the final byte of the word
- in_cin  in  1  word carry-in, sampled only on the first beat
- out_valid  out  1  sum beat valid
- out_ready  in  1  downstream accepts the sum beat
- out_sum  out  8  sum byte
- out_last  out  1  sum beat is the final byte of the word
- out_carry  out  1  unsigned carry-out of the word; meaningful only when out_last=1, otherwise 0
- out_ovf  out  1  signed overflow of the word; meaningful only when out_last=1, otherwise 0
- busy  out  1  state is RUN, i.e. a word is partially processed

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, out_sum=0, out_last=0, out_carry=0, out_ovf=0.
  - carry_q=0, cnt=0, state=IDLE, busy=0.
- Handshake:
  - accept = in_valid & in_ready.
  - in_ready = !out_valid | out_ready, so the output register is refilled in the same cycle it drains.
  - Output fields hold stable while out_valid=1 and out_ready=0.
- Latency: exactly one cycle from an accepted beat to out_valid. Throughput is one beat per cycle.
- Arithmetic on accept:
  - {c8, s} = in_a + in_b + cin_eff, computed with 9-bit width.
  - cin_eff = in_cin if the beat is first, else carry_q.
  - Signed overflow: ovf = (in_a[7] == in_b[7]) & (s[7] != in_a[7]).
- A beat is "first" when in_first=1 or state=IDLE. In IDLE, in_first is implied.
- A beat is "last" when in_last=1 or the beat index cnt_eff == NBYTES-1, where cnt_eff = 0 on a first beat, else cnt. Forced-last truncates the word.
- State machine (IDLE, RUN):
  - IDLE, accept of a non-last beat: go to RUN, cnt=1, carry_q=c8.
  - IDLE, accept of a last beat (single-byte word): stay IDLE, cnt=0, carry_q=0.
  - RUN, accept with in_first=1: abandon the current word and restart, with cin_eff=in_cin and cnt_eff=0. Already-emitted bytes are not recalled.
  - RUN, accept of a non-last beat: cnt++, carry_q=c8.
  - RUN, accept of a last beat: go to IDLE, cnt=0, carry_q=0.
  - No accept: state, cnt and carry_q hold.
- Output register on accept:
  - out_sum=s, out_last=last.
  - out_carry = last ? c8 : 0; out_ovf = last ? ovf : 0.
  - out_valid=1.
- Without accept: on out_ready=1, out_valid goes to 0 and the data fields hold their value.
- Simultaneous drain and accept in one cycle: new data is loaded and out_valid stays 1.
- Reset mid-word discards carry_q and cnt; the next beat is treated as first.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port in_sub (1 bit), sampled on the first beat and held in sub_q for the rest of the word.
  - When the subtract mode is active, B is inverted (~in_b) and the first-beat cin_eff is forced to 1 (in_cin is ignored), giving A-B two's complement.
  - out_carry=1 means no borrow.
  - Overflow is computed on the inverted B.
- Undefined: no in_sub port; the block is add-only.

Decomposition:
- Package serial_add_pkg:
  - BYTE_W=8.
  - State encoding constants ST_IDLE=1'b0, ST_RUN=1'b1.
- Sub-module byte_add_cell: combinational, a[7:0], b[7:0], cin -> s[7:0], cout, ovf. Instantiated once.
- Counter, FSM and output register live in the top module.

Test Plan:
- Single-byte word: first=1, last=1, A=0x01, B=0x01, cin=0 -> next cycle out_sum=0x02, out_last=1, out_carry=0, out_ovf=0.
- Two-byte word, 0x00FF+0x0001:
  - Beat (0xFF, 0x01) -> out_sum=0x00, out_last=0.
  - Beat (0x00, 0x00, last) -> out_sum=0x01, out_last=1, out_carry=0.
- Word 0xFFFF+0x0001 -> bytes 0x00, 0x00, out_carry=1. Signed overflow: 0x7F+0x01 single byte -> out_sum=0x80, out_ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_sum stable, no beat lost. Releasing out_ready gives back-to-back output.
- Forced last, NBYTES=4: four beats with in_last=0 -> 4th output has out_last=1 and busy drops to 0. A 5th beat is treated as first (cin=in_cin).
- Reset and restart:
  - Assert rst_n=0 after two beats of 0xFF+0x01 -> all outputs 0 immediately.
  - Next beat 0x01+0x01 -> 0x02, carry-in taken from in_cin, not the stale carry.
  - Mid-word in_first=1 also restarts the carry chain.
